// File: rtl/fifo_read_arbiter.sv
// Two-channel FIFO read arbiter: round-robin bursts of up to MAX_BURST pops per channel
// into a single registered output word with valid/ready handshake.
module fifo_read_arbiter #(
    parameter int DSIZE     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             rempty0,
    input  logic             rempty1,
    input  logic [DSIZE-1:0] rdata0,
    input  logic [DSIZE-1:0] rdata1,
    output logic             rinc0,
    output logic             rinc1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DSIZE-1:0] out_data,
    output logic             out_src
);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] LAST = CW'(MAX_BURST - 1);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    state_t        state;
    logic          last_grant;
    logic [CW-1:0] burst_cnt;
    // High for the first cycle after a burst-end handover so the switch costs one pop-free cycle.
    logic          sw_bubble;
    logic          can_load;

    assign can_load = !out_valid || out_ready;
    assign rinc0    = (state == GRANT0) && !rempty0 && can_load && !sw_bubble;
    assign rinc1    = (state == GRANT1) && !rempty1 && can_load && !sw_bubble;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            burst_cnt  <= '0;
            sw_bubble  <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_src    <= 1'b0;
        end else begin
            if (can_load) begin
                if (rinc0) begin
                    out_data  <= rdata0;
                    out_src   <= 1'b0;
                    out_valid <= 1'b1;
                end else if (rinc1) begin
                    out_data  <= rdata1;
                    out_src   <= 1'b1;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end
            sw_bubble <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rempty0 && (rempty1 || last_grant)) begin
                        state      <= GRANT0;
                        last_grant <= 1'b0;
                        burst_cnt  <= '0;
                    end else if (!rempty1) begin
                        state      <= GRANT1;
                        last_grant <= 1'b1;
                        burst_cnt  <= '0;
                    end
                end
                GRANT0: begin
                    if (rempty0) begin
                        if (!rempty1) begin
                            state      <= GRANT1;
                            last_grant <= 1'b1;
                            burst_cnt  <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (rinc0) begin
                        if (burst_cnt == LAST) begin
                            if (!rempty1) begin
                                state      <= GRANT1;
                                last_grant <= 1'b1;
                                burst_cnt  <= '0;
                                sw_bubble  <= 1'b1;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            burst_cnt <= burst_cnt + CW'(1);
                        end
                    end
                end
                GRANT1: begin
                    if (rempty1) begin
                        if (!rempty0) begin
                            state      <= GRANT0;
                            last_grant <= 1'b0;
                            burst_cnt  <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (rinc1) begin
                        if (burst_cnt == LAST) begin
                            if (!rempty0) begin
                                state      <= GRANT0;
                                last_grant <= 1'b0;
                                burst_cnt  <= '0;
                                sw_bubble  <= 1'b1;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            burst_cnt <= burst_cnt + CW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Directed bench for fifo_read_arbiter: queue-backed FIFO models, an accept log with
// cycle stamps, and hand-computed expected orders and gaps.
module tb_fifo_read_arbiter;
    logic       rclk = 1'b0;
    logic       rrst_n = 1'b0;
    logic       rempty0 = 1'b1, rempty1 = 1'b1;
    logic [7:0] rdata0 = '0, rdata1 = '0;
    logic       rinc0, rinc1;
    logic       out_valid, out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_src;

    fifo_read_arbiter #(.DSIZE(8), .MAX_BURST(4)) dut (
        .rclk(rclk), .rrst_n(rrst_n),
        .rempty0(rempty0), .rempty1(rempty1),
        .rdata0(rdata0), .rdata1(rdata1),
        .rinc0(rinc0), .rinc1(rinc1),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_src(out_src)
    );

    always #5 rclk = ~rclk;

    logic [7:0] q0[$], q1[$];
    logic [8:0] log_w[$];
    int         log_c[$];
    int         cyc = 0, cnt0 = 0, cnt1 = 0, both_hi = 0;
    int         n_run = 0, n_fail = 0;
    logic [7:0] dump;

    // FIFO pop and output accept happen on the rising edge.
    always @(posedge rclk) begin
        cyc <= cyc + 1;
        if (rinc0 && rinc1) both_hi <= both_hi + 1;
        if (rinc0) begin dump = q0.pop_front(); cnt0 <= cnt0 + 1; end
        if (rinc1) begin dump = q1.pop_front(); cnt1 <= cnt1 + 1; end
        if (rrst_n && out_valid && out_ready) begin
            log_w.push_back({out_src, out_data});
            log_c.push_back(cyc);
        end
    end

    // Registered empty flags / read data refreshed mid-cycle from the queues.
    always @(negedge rclk) begin
        rempty0 = (q0.size() == 0);
        rempty1 = (q1.size() == 0);
        rdata0  = (q0.size() != 0) ? q0[0] : 8'h00;
        rdata1  = (q1.size() != 0) ? q1[0] : 8'h00;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin @(negedge rclk); #1; end
    endtask

    task automatic do_reset();
        rrst_n = 1'b0; run(2); rrst_n = 1'b1; run(1);
    endtask

    task automatic wait_valid(input int max);
        int k = 0;
        while (!out_valid && k < max) begin run(1); k++; end
        if (!out_valid) chk("timeout_out_valid", 32'd0, 32'd1);
    endtask

    task automatic chk_log(input string tag, input int b, input logic [8:0] ew[], input int eg[]);
        chk({tag, "_n"}, log_w.size() - b, ew.size());
        for (int i = 0; i < ew.size(); i++)
            if (b + i < log_w.size()) chk({tag, "_word"}, log_w[b+i], ew[i]);
        for (int i = 0; i < eg.size(); i++)
            if (b + i + 1 < log_c.size()) chk({tag, "_gap"}, log_c[b+i+1] - log_c[b+i], eg[i]);
    endtask

    initial begin
        int b, r0, r1, any, k;
        logic [8:0] ew[];
        int eg[];

        // Reset state
        run(2);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_src", out_src, 0);
        chk("rst_rinc", {rinc0, rinc1}, 0);
        rrst_n = 1'b1;

        // Both empty for 10 cycles
        any = 0;
        repeat (10) begin run(1); any |= {rinc0, rinc1, out_valid}; end
        chk("idle_quiet", any, 0);
        chk("idle_cnt", dut.burst_cnt, 0);

        // Single channel, burst of 4 then idle cycle then 2 more
        b = log_w.size(); r0 = cnt0;
        for (int i = 0; i < 6; i++) q0.push_back(8'(8'hA0 + i));
        run(16);
        ew = new[6]; for (int i = 0; i < 6; i++) ew[i] = {1'b0, 8'(8'hA0 + i)};
        eg = '{1, 1, 1, 2, 1};
        chk_log("single", b, ew, eg);
        chk("single_rinc0", cnt0 - r0, 6);

        // Both channels with 8 words: alternating bursts, one bubble per switch
        do_reset();
        b = log_w.size();
        for (int i = 0; i < 8; i++) begin q0.push_back(8'(i)); q1.push_back(8'(8'h10 + i)); end
        run(30);
        ew = new[16];
        for (int i = 0; i < 4; i++) begin
            ew[i]    = {1'b0, 8'(i)};
            ew[4+i]  = {1'b1, 8'(8'h10 + i)};
            ew[8+i]  = {1'b0, 8'(4 + i)};
            ew[12+i] = {1'b1, 8'(8'h14 + i)};
        end
        eg = '{1,1,1,2, 1,1,1,2, 1,1,1,2, 1,1,1};
        chk_log("rr", b, ew, eg);

        // Output stall holds word, counter and pop count
        do_reset();
        b = log_w.size(); r1 = cnt1;
        for (int i = 0; i < 3; i++) q1.push_back(8'(8'h30 + i));
        wait_valid(10);
        out_ready = 1'b0;
        run(5);
        chk("stall_data", out_data, 8'h30);
        chk("stall_valid", out_valid, 1);
        chk("stall_rinc1", cnt1 - r1, 1);
        chk("stall_cnt", dut.burst_cnt, 1);
        out_ready = 1'b1;
        run(6);
        ew = '{9'h130, 9'h131, 9'h132};
        eg = '{1, 1};
        chk_log("stall", b, ew, eg);

        // Channel 0 runs dry mid-burst: switch to ch1 on the same edge, counter restarts
        do_reset();
        b = log_w.size();
        q0.push_back(8'h40); q0.push_back(8'h41);
        for (int i = 0; i < 3; i++) q1.push_back(8'(8'h50 + i));
        k = 0;
        while (!rinc1 && k < 20) begin run(1); k++; end
        chk("dry_rinc1_seen", rinc1, 1);
        chk("dry_rinc0", rinc0, 0);
        chk("dry_cnt", dut.burst_cnt, 0);
        run(8);
        ew = '{9'h040, 9'h041, 9'h150, 9'h151, 9'h152};
        eg = '{1, 2, 1, 1};
        chk_log("dry", b, ew, eg);

        // Reset mid-burst with a held word; channel 0 wins after release
        do_reset();
        out_ready = 1'b0;
        q1.push_back(8'h60); q1.push_back(8'h61);
        wait_valid(10);
        q0.push_back(8'h70); q0.push_back(8'h71);
        run(2);
        rrst_n = 1'b0;
        #1;
        chk("mrst_valid", out_valid, 0);
        chk("mrst_data", out_data, 0);
        chk("mrst_rinc", {rinc0, rinc1}, 0);
        r0 = cnt0; r1 = cnt1;
        run(1);
        chk("mrst_nopop", (cnt0 - r0) + (cnt1 - r1), 0);
        b = log_w.size();
        rrst_n = 1'b1; out_ready = 1'b1;
        run(12);
        chk("mrst_n", log_w.size() - b, 3);
        if (log_w.size() > b) chk("mrst_first", log_w[b], 9'h070);

        chk("never_both_rinc", both_hi, 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
